fault_inject_logic2: RTL and testbench

Fault-injectable five-input, two-output combinational gate network with registered outputs. It carries two copies of the same 11-gate netlist. The golden copy is always fault-free. The fault copy can force any one of 16 numbered nodes to a stuck-at value. Used as the device under test in exhaustive single-stuck-at fault-coverage runs, where mismatch between the two copies marks a detected fault.

---
 rtl/fault_inject_logic2.sv | 89 ++++++++
 tb/tb_fault_inject_logic2.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fault_inject_logic2.sv
// Golden and stuck-at-faultable copies of one 11-gate NAND/AND/OR/NOR/XOR
// network, with registered outputs, a per-sample mismatch flag and a sticky detect flag.

module fault_inject_net (
  input  logic       fault_en,
  input  logic [4:0] fault_sel,
  input  logic       fault_val,
  input  logic [4:0] pin,
  output logic [1:0] out
);
  logic [16:1] hit;
  logic [16:1] n;

  // A node is forced only when this copy has faults enabled and sel names it.
  for (genvar k = 1; k <= 16; k++) begin : g_hit
    assign hit[k] = fault_en && (fault_sel == 5'(k));
  end

  // The forced value replaces the node at its driver, so every fanout sees it.
  always_comb begin
    n      = '0;
    n[1]   = hit[1]  ? fault_val : pin[4];
    n[2]   = hit[2]  ? fault_val : pin[3];
    n[3]   = hit[3]  ? fault_val : pin[2];
    n[4]   = hit[4]  ? fault_val : pin[1];
    n[5]   = hit[5]  ? fault_val : pin[0];
    n[6]   = hit[6]  ? fault_val : ~(n[1] & n[3]);
    n[7]   = hit[7]  ? fault_val : ~(n[3] & n[4]);
    n[8]   = hit[8]  ? fault_val : ~(n[2] & n[7]);
    n[9]   = hit[9]  ? fault_val : ~(n[7] & n[5]);
    n[10]  = hit[10] ? fault_val : ~(n[6] & n[8]);
    n[11]  = hit[11] ? fault_val : ~(n[8] & n[9]);
    n[12]  = hit[12] ? fault_val : (n[1] & n[5]);
    n[13]  = hit[13] ? fault_val : (n[10] | n[12]);
    n[14]  = hit[14] ? fault_val : ~(n[11] | n[2]);
    n[15]  = hit[15] ? fault_val : (n[13] ^ n[14]);
    n[16]  = hit[16] ? fault_val : ~(n[11] & n[13]);
  end

  assign out = {n[15], n[16]};
endmodule

module fault_inject_logic2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] fault_sel,
  input  logic       fault_val,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  input  logic       in4,
  input  logic       in5,
  output logic       o1,
  output logic       o2,
  output logic       g1,
  output logic       g2,
  output logic       mismatch,
  output logic       detected
);
  // Copy 0 is golden, copy 1 carries the fault muxes.
  logic [1:0][1:0] net_out;
  logic            mm_next;

  for (genvar c = 0; c < 2; c++) begin : g_copy
    fault_inject_net u_net (
      .fault_en  (c == 1),
      .fault_sel (fault_sel),
      .fault_val (fault_val),
      .pin       ({in1, in2, in3, in4, in5}),
      .out       (net_out[c])
    );
  end

  assign mm_next = |(net_out[1] ^ net_out[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      {o1, o2}  <= 2'b00;
      {g1, g2}  <= 2'b00;
      mismatch  <= 1'b0;
      detected  <= 1'b0;
    end else begin
      {o1, o2}  <= net_out[1];
      {g1, g2}  <= net_out[0];
      mismatch  <= mm_next;
      detected  <= detected | mm_next;
    end
  end
endmodule

// File: tb/tb_fault_inject_logic2.sv
// Self-checking bench: directed cases, full single-stuck-at sweep and random
// stimulus against a table-driven netlist model.

module tb_fault_inject_logic2;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] fault_sel;
  logic       fault_val;
  logic       in1, in2, in3, in4, in5;
  logic       o1, o2, g1, g2, mismatch, detected;

  int checks = 0;
  int failures = 0;
  logic exp_det;

  always #5 clk = ~clk;

  fault_inject_logic2 dut (
    .clk(clk), .rst(rst), .fault_sel(fault_sel), .fault_val(fault_val),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
    .o1(o1), .o2(o2), .g1(g1), .g2(g2),
    .mismatch(mismatch), .detected(detected)
  );

  // Gate table: op 0=NAND 1=AND 2=OR 3=NOR 4=XOR, operand node numbers a,b.
  function automatic logic [1:0] ref_eval(input logic [4:0] p, input int sel, input logic v);
    logic nv [1:16];
    int op, a, b;
    for (int k = 1; k <= 16; k++) begin
      if (k <= 5) nv[k] = p[5-k];
      else begin
        case (k)
          6:  begin op = 0; a = 1;  b = 3;  end
          7:  begin op = 0; a = 3;  b = 4;  end
          8:  begin op = 0; a = 2;  b = 7;  end
          9:  begin op = 0; a = 7;  b = 5;  end
          10: begin op = 0; a = 6;  b = 8;  end
          11: begin op = 0; a = 8;  b = 9;  end
          12: begin op = 1; a = 1;  b = 5;  end
          13: begin op = 2; a = 10; b = 12; end
          14: begin op = 3; a = 11; b = 2;  end
          15: begin op = 4; a = 13; b = 14; end
          default: begin op = 0; a = 11; b = 13; end
        endcase
        case (op)
          0: nv[k] = !(nv[a] && nv[b]);
          1: nv[k] = nv[a] && nv[b];
          2: nv[k] = nv[a] || nv[b];
          3: nv[k] = !(nv[a] || nv[b]);
          default: nv[k] = nv[a] != nv[b];
        endcase
      end
      if (sel == k) nv[k] = v;
    end
    return {nv[15], nv[16]};
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] p, input int sel, input logic v);
    {in1, in2, in3, in4, in5} = p;
    fault_sel = 5'(sel);
    fault_val = v;
  endtask

  // One sample: drive, clock, then check every output against the model.
  task automatic step(input logic [4:0] p, input int sel, input logic v);
    logic [1:0] eo, eg;
    logic em;
    drive(p, sel, v);
    eo = ref_eval(p, sel, v);
    eg = ref_eval(p, 0, 1'b0);
    em = (eo != eg);
    exp_det = exp_det | em;
    @(posedge clk); #1;
    chk("o", {o1, o2}, eo);
    chk("g", {g1, g2}, eg);
    chk("mismatch", {1'b0, mismatch}, {1'b0, em});
    chk("detected", {1'b0, detected}, {1'b0, exp_det});
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_det = 1'b0;
    chk("rst_o", {o1, o2}, 2'b00);
    chk("rst_g", {g1, g2}, 2'b00);
    chk("rst_flags", {mismatch, detected}, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    exp_det = 1'b0;
    drive(5'b11111, 13, 1'b1);
    @(posedge clk); #1;
    do_reset(2);

    // Fault-free exhaustive.
    for (int p = 0; p < 32; p++) step(5'(p), 0, 1'b0);

    // Directed spot values with hand-derived constants.
    step(5'b00000, 0, 1'b0);   chk("spot0_g", {g1, g2}, 2'b11);
    step(5'b11111, 0, 1'b0);   chk("spot31_g", {g1, g2}, 2'b11);
    step(5'b00000, 13, 1'b1);
    chk("n13sa1_o", {o1, o2}, 2'b01);
    chk("n13sa1_flags", {mismatch, detected}, 2'b11);
    // Sticky: mismatch drops, detected holds.
    step(5'b00000, 0, 1'b0);
    chk("sticky", {mismatch, detected}, 2'b01);
    step(5'b00000, 14, 1'b0);  chk("n14sa0_o", {o1, o2}, 2'b01);
    step(5'b11111, 11, 1'b1);
    chk("n11sa1_o", {o1, o2}, 2'b10);
    chk("n11sa1_mm", {1'b0, mismatch}, 2'b01);
    step(5'b00000, 1, 1'b1);
    chk("n1sa1", {o1, o2, 1'b0, mismatch} , {2'b11, 2'b00});
    step(5'b11111, 12, 1'b0);
    chk("n12sa0", {o1, o2, 1'b0, mismatch}, {2'b11, 2'b00});
    for (int p = 0; p < 32; p += 7) begin
      step(5'(p), 20, p[0]);
      chk("sel20", {1'b0, mismatch}, 2'b00);
    end

    // Mid-run reset discards a mismatching sample.
    drive(5'b00000, 13, 1'b1);
    do_reset(1);

    // Full single-stuck-at sweep.
    for (int k = 1; k <= 16; k++)
      for (int v = 0; v < 2; v++)
        for (int p = 0; p < 32; p++)
          step(5'(p), k, v[0]);

    do_reset(1);
    // Random patterns and settings, including out-of-range selects.
    for (int i = 0; i < 300; i++)
      step(5'($urandom_range(31)), int'($urandom_range(31)), 1'($urandom_range(1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
